// File: rtl/approx_adder_err_monitor_pkg.sv
// rtl/approx_adder_err_monitor_pkg.sv - shared types, LFSR constants and helpers for the adder error monitor
// Purpose: FSM state encoding, operand LFSR taps/seed and the error-distance helper.
// Ports: none (package).
package approx_err_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // x^33 + x^20 + 1: feedback taps on state bits 32 and 19.
  localparam logic [32:0] LFSR_TAPS_W16     = 33'h1_0008_0000;
  localparam logic [32:0] LFSR_SEED_DEFAULT = 33'h1_2345_6789;

  // Wide enough for any operand width the monitor is built with; callers truncate.
  localparam int ABS_W = 64;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] exact,
                                                input logic [ABS_W-1:0] actual);
    return (exact >= actual) ? (exact - actual) : (actual - exact);
  endfunction

endpackage

// File: rtl/approx_adder_err_monitor_lfsr_gen.sv
// rtl/approx_adder_err_monitor_lfsr_gen.sv - Fibonacci LFSR operand generator
// Purpose: N-bit Fibonacci LFSR that advances one step per enabled cycle.
// Ports: clk, rst (async active-high, loads SEED), en_i (advance), state_o (registered state).
module lfsr_gen
  import approx_err_pkg::*;
#(
  parameter int          N    = 33,
  parameter logic [N-1:0] SEED = LFSR_SEED_DEFAULT,
  parameter logic [N-1:0] TAPS = LFSR_TAPS_W16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [N-1:0] state_o
);

  logic [N-1:0] state_q, state_d;

  // Shift toward the MSB; the XOR of the tapped bits enters at bit 0.
  always_comb begin
    state_d = state_q;
    if (en_i) state_d = {state_q[N-2:0], ^(state_q & TAPS)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/approx_adder_err_monitor.sv
// rtl/approx_adder_err_monitor.sv - on-chip error characterisation engine for approximate adders
// Purpose: drives LFSR operand vectors into an external adder, compares {cout,sum} against the
//          exact sum DUT_LAT cycles later and accumulates vector/error counts and error distance.
// Ports: clk, rst (async active-high); start, num_vec, mask_msb (run control);
//        dut_a, dut_b, dut_cin (operands out); dut_sum, dut_cout (adder result in);
//        busy, done (status); vec_cnt, err_cnt, ed_sum, max_ed (results, valid in DONE).
module approx_adder_err_monitor
  import approx_err_pkg::*;
#(
  parameter int                 WIDTH     = 16,
  parameter int                 CNT_W     = 32,
  parameter int                 DUT_LAT   = 0,
  parameter logic [2*WIDTH:0]   LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_vec,
  input  logic                   mask_msb,
  output logic [WIDTH-1:0]       dut_a,
  output logic [WIDTH-1:0]       dut_b,
  output logic                   dut_cin,
  input  logic [WIDTH-1:0]       dut_sum,
  input  logic                   dut_cout,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       vec_cnt,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [CNT_W+WIDTH:0]   ed_sum,
  output logic [WIDTH:0]         max_ed
);

  localparam int LW = 2*WIDTH + 1;
  localparam int EW = WIDTH + 1;
  localparam int SW = CNT_W + WIDTH + 1;
  localparam logic [LW-1:0] TAPS = LW'(LFSR_TAPS_W16);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic [2:0]        drain_q, drain_d;
  logic              mask_q, mask_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, op_keep;
  logic              cin_q, cin_d;
  logic [LW-1:0]     lfsr_q;
  logic              lfsr_en, accept, run_valid;
  logic [EW-1:0]     exact_now, cmp_exact, actual, ed;
  logic              cmp_valid;
  logic [CNT_W-1:0]  vec_cnt_q, err_cnt_q;
  logic [SW-1:0]     ed_sum_q;
  logic [EW-1:0]     max_ed_q;

  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  lfsr_gen #(.N(LW), .SEED(LFSR_SEED), .TAPS(TAPS)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en_i    (lfsr_en),
    .state_o (lfsr_q)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (accept) state_d = (num_vec != '0) ? ST_RUN : ST_DONE;
      ST_RUN:   if (left_q == CNT_W'(1)) state_d = (DUT_LAT == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (drain_q == 3'd1) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done = (state_q == ST_DONE);
  end

  // Run/drain counters and operand registers. Operands are loaded on every edge that
  // enters or stays in RUN, so the LFSR step and the presented vector stay paired.
  always_comb begin
    left_d  = left_q;
    drain_d = drain_q;
    mask_d  = mask_q;
    if (accept) begin
      left_d = num_vec;
      mask_d = mask_msb;
    end else if (state_q == ST_RUN) begin
      left_d = left_q - CNT_W'(1);
    end
    if (state_q == ST_RUN)        drain_d = 3'(DUT_LAT);
    else if (state_q == ST_DRAIN) drain_d = drain_q - 3'd1;

    lfsr_en = (state_d == ST_RUN);
    op_keep = mask_d ? {1'b0, {(WIDTH-1){1'b1}}} : '1;
    a_d     = lfsr_en ? (lfsr_q[WIDTH-1:0] & op_keep)       : '0;
    b_d     = lfsr_en ? (lfsr_q[2*WIDTH-1:WIDTH] & op_keep) : '0;
    cin_d   = lfsr_en ? lfsr_q[2*WIDTH] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q  <= '0;
      drain_q <= '0;
      mask_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
    end else begin
      left_q  <= left_d;
      drain_q <= drain_d;
      mask_q  <= mask_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
    end
  end

  assign dut_a   = a_q;
  assign dut_b   = b_q;
  assign dut_cin = cin_q;

  assign run_valid = (state_q == ST_RUN);
  assign exact_now = EW'(a_q) + EW'(b_q) + EW'(cin_q);

  // Expected value delay line, aligned with the adder's pipeline latency.
  generate
    if (DUT_LAT == 0) begin : g_nodly
      assign cmp_valid = run_valid;
      assign cmp_exact = exact_now;
    end else begin : g_dly
      logic          vld_q [DUT_LAT];
      logic [EW-1:0] ex_q  [DUT_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DUT_LAT; i++) begin
            vld_q[i] <= 1'b0;
            ex_q[i]  <= '0;
          end
        end else begin
          vld_q[0] <= run_valid;
          ex_q[0]  <= exact_now;
          for (int i = 1; i < DUT_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            ex_q[i]  <= ex_q[i-1];
          end
        end
      end
      assign cmp_valid = vld_q[DUT_LAT-1];
      assign cmp_exact = ex_q[DUT_LAT-1];
    end
  endgenerate

  assign actual = {dut_cout, dut_sum};
  assign ed     = EW'(abs_diff(ABS_W'(cmp_exact), ABS_W'(actual)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      ed_sum_q  <= '0;
      max_ed_q  <= '0;
    end else if (accept) begin
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
      ed_sum_q  <= '0;
      max_ed_q  <= '0;
    end else if (cmp_valid) begin
      vec_cnt_q <= vec_cnt_q + CNT_W'(1);
      err_cnt_q <= err_cnt_q + CNT_W'(ed != '0);
      ed_sum_q  <= ed_sum_q + SW'(ed);
      if (ed > max_ed_q) max_ed_q <= ed;
    end
  end

  assign vec_cnt = vec_cnt_q;
  assign err_cnt = err_cnt_q;
  assign ed_sum  = ed_sum_q;
  assign max_ed  = max_ed_q;

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// tb/tb_approx_adder_err_monitor.sv - self-checking bench for approx_adder_err_monitor
module tb_approx_adder_err_monitor;

  localparam int W  = 16;
  localparam int CW = 32;
  localparam int SW = CW + W + 1;
  localparam int EW = W + 1;
  localparam logic [2*W:0] SEED = 33'h1_2345_6789;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start   [2];
  logic [CW-1:0] num_vec [2];
  logic          mask    [2];
  logic [1:0]    mode    [2];
  logic [W-1:0]  da [2];
  logic [W-1:0]  db [2];
  logic          dc [2];
  logic [W-1:0]  ds [2];
  logic          dco [2];
  logic          busy [2];
  logic          done [2];
  logic [CW-1:0] vc [2];
  logic [CW-1:0] ec [2];
  logic [SW-1:0] es [2];
  logic [EW-1:0] me [2];

  int n_vec  = 0;
  int n_fail = 0;
  int n_cmp  = 0;

  logic [2*W:0] lf [2];
  logic [2*W:0] q0 [$];
  logic [2*W:0] q1 [$];

  // Adder-under-test behaviours: 0 exact, 1 LSB inverted, 2 cout tied 0,
  // 3 lower-part-OR approximation (low 4 bits OR'ed, no carry into the upper part).
  function automatic logic [EW-1:0] approx(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic [1:0] m);
    logic [EW-1:0] ex;
    ex = EW'(a) + EW'(b) + EW'(c);
    case (m)
      2'd0:    return ex;
      2'd1:    return ex ^ EW'(1);
      2'd2:    return {1'b0, ex[W-1:0]};
      default: return ((EW'(a >> 4) + EW'(b >> 4)) << 4) | EW'(a[3:0] | b[3:0]);
    endcase
  endfunction

  assign {dco[0], ds[0]} = approx(da[0], db[0], dc[0], mode[0]);

  logic [EW-1:0] p1 = '0;
  logic [EW-1:0] p2 = '0;
  always @(posedge clk) begin
    p1 <= approx(da[1], db[1], dc[1], mode[1]);
    p2 <= p1;
  end
  assign {dco[1], ds[1]} = p2;

  approx_adder_err_monitor #(.WIDTH(W), .CNT_W(CW), .DUT_LAT(0), .LFSR_SEED(SEED)) u_lat0 (
    .clk(clk), .rst(rst), .start(start[0]), .num_vec(num_vec[0]), .mask_msb(mask[0]),
    .dut_a(da[0]), .dut_b(db[0]), .dut_cin(dc[0]), .dut_sum(ds[0]), .dut_cout(dco[0]),
    .busy(busy[0]), .done(done[0]), .vec_cnt(vc[0]), .err_cnt(ec[0]),
    .ed_sum(es[0]), .max_ed(me[0])
  );

  approx_adder_err_monitor #(.WIDTH(W), .CNT_W(CW), .DUT_LAT(2), .LFSR_SEED(SEED)) u_lat2 (
    .clk(clk), .rst(rst), .start(start[1]), .num_vec(num_vec[1]), .mask_msb(mask[1]),
    .dut_a(da[1]), .dut_b(db[1]), .dut_cin(dc[1]), .dut_sum(ds[1]), .dut_cout(dco[1]),
    .busy(busy[1]), .done(done[1]), .vec_cnt(vc[1]), .err_cnt(ec[1]),
    .ed_sum(es[1]), .max_ed(me[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Operand stream check: every cycle a run is in progress the next expected vector
  // must be on the operand bus; whenever none is pending the bus must be all zero.
  always @(negedge clk) begin
    logic [2*W:0] v;
    if (busy[0] && q0.size() != 0) begin
      v = q0.pop_front();
      n_vec++;
      chk("ops_lat0", 64'({dc[0], db[0], da[0]}), 64'(v));
    end else begin
      chk("idle_ops_lat0", 64'({dc[0], db[0], da[0]}), 64'd0);
    end
    if (busy[1] && q1.size() != 0) begin
      v = q1.pop_front();
      n_vec++;
      chk("ops_lat2", 64'({dc[1], db[1], da[1]}), 64'(v));
    end else begin
      chk("idle_ops_lat2", 64'({dc[1], db[1], da[1]}), 64'd0);
    end
  end

  // Generates the run's vectors from the reference LFSR and the expected statistics.
  task automatic prep(input int k, input int n, input logic m, input logic [1:0] md,
                      output longint e_err, output longint e_sum, output longint e_max);
    logic [W-1:0] a, b;
    logic ci;
    longint ex, ac, ed;
    e_err = 0; e_sum = 0; e_max = 0;
    mode[k] = md;
    for (int i = 0; i < n; i++) begin
      a  = lf[k][W-1:0];
      b  = lf[k][2*W-1:W];
      ci = lf[k][2*W];
      if (m) begin
        a[W-1] = 1'b0;
        b[W-1] = 1'b0;
      end
      if (k == 0) q0.push_back({ci, b, a});
      else        q1.push_back({ci, b, a});
      ex = longint'(a) + longint'(b) + longint'(ci);
      ac = longint'(approx(a, b, ci, md));
      ed = (ex > ac) ? ex - ac : ac - ex;
      if (ed != 0) e_err++;
      e_sum += ed;
      if (ed > e_max) e_max = ed;
      lf[k] = {lf[k][2*W-1:0], lf[k][2*W] ^ lf[k][19]};
    end
  endtask

  task automatic run(input int k, input int n, input logic m, input logic [1:0] md,
                     input int poke, input bit pin);
    longint e_err, e_sum, e_max;
    int lat, c, bc, exp_c, qleft;
    lat = (k == 0) ? 0 : 2;
    prep(k, n, m, md, e_err, e_sum, e_max);
    @(posedge clk); #1;
    num_vec[k] = n;
    mask[k]    = m;
    start[k]   = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    c  = 0;
    bc = busy[k] ? 1 : 0;
    if (pin) begin
      chk("seed_vec0_a", 64'(da[k]), 64'h6789);
      chk("seed_vec0_b", 64'(db[k]), 64'h2345);
      chk("seed_vec0_cin", 64'(dc[k]), 64'd1);
    end
    while (!done[k] && c < n + lat + 20) begin
      @(posedge clk); #1;
      c++;
      if (busy[k]) bc++;
      if (pin && c == 1) begin
        chk("seed_vec1_a", 64'(da[k]), 64'hCF13);
        chk("seed_vec1_b", 64'(db[k]), 64'h468A);
        chk("seed_vec1_cin", 64'(dc[k]), 64'd0);
      end
      if (c == poke) begin
        num_vec[k] = 7;
        start[k]   = 1'b1;
      end else begin
        start[k] = 1'b0;
      end
    end
    exp_c = (n == 0) ? 0 : n + lat;
    qleft = (k == 0) ? q0.size() : q1.size();
    chk("done_latency", 64'(c), 64'(exp_c));
    chk("busy_cycles", 64'(bc), 64'(exp_c));
    chk("done_flag", 64'(done[k]), 64'd1);
    chk("vectors_unconsumed", 64'(qleft), 64'd0);
    chk("vec_cnt", 64'(vc[k]), 64'(n));
    chk("err_cnt", 64'(ec[k]), 64'(e_err));
    chk("ed_sum", 64'(es[k]), 64'(e_sum));
    chk("max_ed", 64'(me[k]), 64'(e_max));
  endtask

  initial begin
    longint e_err, e_sum, e_max;
    int k, n;
    logic m;
    logic [1:0] md;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; num_vec[i] = '0; mask[i] = 1'b0; mode[i] = 2'd0; lf[i] = SEED;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", 64'(busy[i]), 64'd0);
      chk("rst_done", 64'(done[i]), 64'd0);
      chk("rst_vec_cnt", 64'(vc[i]), 64'd0);
      chk("rst_err_cnt", 64'(ec[i]), 64'd0);
      chk("rst_ed_sum", 64'(es[i]), 64'd0);
      chk("rst_max_ed", 64'(me[i]), 64'd0);
    end
    rst = 1'b0;

    run(0, 1000, 1'b0, 2'd0, 0, 1'b1);
    chk("exact_vec_cnt", 64'(vc[0]), 64'd1000);
    chk("exact_err_cnt", 64'(ec[0]), 64'd0);
    chk("exact_ed_sum", 64'(es[0]), 64'd0);
    chk("exact_max_ed", 64'(me[0]), 64'd0);

    run(0, 256, 1'b0, 2'd1, 0, 1'b0);
    chk("lsbinv_err_cnt", 64'(ec[0]), 64'd256);
    chk("lsbinv_ed_sum", 64'(es[0]), 64'd256);
    chk("lsbinv_max_ed", 64'(me[0]), 64'd1);

    run(0, 500, 1'b1, 2'd2, 0, 1'b0);
    chk("cout0_masked_err_cnt", 64'(ec[0]), 64'd0);

    run(0, 500, 1'b0, 2'd2, 0, 1'b0);
    chk("cout0_max_ed", 64'(me[0]), 64'd65536);
    chk("cout0_ed_sum", 64'(es[0]), 64'(ec[0]) << 16);

    run(1, 100, 1'b0, 2'd0, 3, 1'b0);
    chk("lat2_vec_cnt", 64'(vc[1]), 64'd100);
    chk("lat2_err_cnt", 64'(ec[1]), 64'd0);

    run(0, 0, 1'b0, 2'd0, 0, 1'b0);
    chk("zero_run_vec_cnt", 64'(vc[0]), 64'd0);
    chk("zero_run_ed_sum", 64'(es[0]), 64'd0);
    run(0, 10, 1'b0, 2'd3, 0, 1'b0);
    chk("after_zero_vec_cnt", 64'(vc[0]), 64'd10);

    // Reset in the middle of a run.
    prep(0, 50, 1'b0, 2'd1, e_err, e_sum, e_max);
    @(posedge clk); #1;
    num_vec[0] = 50; mask[0] = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_done", 64'(done[0]), 64'd0);
    chk("abort_vec_cnt", 64'(vc[0]), 64'd0);
    chk("abort_err_cnt", 64'(ec[0]), 64'd0);
    chk("abort_ed_sum", 64'(es[0]), 64'd0);
    chk("abort_max_ed", 64'(me[0]), 64'd0);
    chk("abort_dut_a", 64'(da[0]), 64'd0);
    chk("abort_dut_b", 64'(db[0]), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    lf[0] = SEED;
    lf[1] = SEED;
    run(0, 3, 1'b0, 2'd0, 0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      k  = int'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 200));
      m  = 1'($urandom_range(0, 1));
      md = 2'($urandom_range(0, 3));
      run(k, n, m, md, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
